// File: rtl/piano_poly_envelope_synth_if.sv
// Audio output FIFO bus between the synth and Audio_Controller.
// master: synth (drives write strobe and samples); slave: controller (drives allowed).
interface piano_poly_envelope_synth_if;
  logic               audio_out_allowed;
  logic               write_audio_out;
  logic signed [31:0] left_channel_audio_out;
  logic signed [31:0] right_channel_audio_out;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );
endinterface

// File: rtl/piano_poly_envelope_synth.sv
// Polyphonic square-wave key synth with per-voice sustain/release envelope.
// Ports: CLOCK_50, resetn (sync, low), keys, aud (FIFO bus, master), voice_active.
// Define VOICE_DECAY_EN for piano mode (held notes decay); default is organ mode.
module piano_poly_envelope_synth #(
  parameter int NUM_KEYS = 10,
  parameter int HP_W = 19,
  parameter logic [NUM_KEYS*HP_W-1:0] HALF_PERIODS = {
    19'd37921, 19'd42565, 19'd47777, 19'd50619, 19'd56817,
    19'd63775, 19'd71585, 19'd75842, 19'd85131, 19'd95554
  },
  parameter int VOL_W = 8,
  parameter int VOL_INIT = 255,
  parameter int AMP_STEP = 39216,
  parameter int DECAY_TICKS = 50000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keys,
  piano_poly_envelope_synth_if.master aud,
  output logic [NUM_KEYS-1:0] voice_active
);

  typedef enum logic [1:0] {
    IDLE,
    SUSTAIN,
    RELEASE
  } state_t;

  localparam int TICK_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  // voice width holds VOL_INIT*AMP_STEP plus sign without overflow
  localparam int VV_W = VOL_W + 32;
  localparam int MIX_W = VV_W + $clog2(NUM_KEYS) + 1;

  localparam logic [VOL_W-1:0]  VOL_LOAD = VOL_W'(VOL_INIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DECAY_TICKS - 1);
  localparam logic signed [MIX_W-1:0] POS_LIM =
    $signed({{(MIX_W-32){1'b0}}, 32'h7fff_ffff});
  localparam logic signed [MIX_W-1:0] NEG_LIM = -POS_LIM;

  logic [NUM_KEYS-1:0] keys_q;
  logic [NUM_KEYS-1:0] keys_q_d;
  logic [NUM_KEYS-1:0] rise;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      keys_q   <= '0;
      keys_q_d <= '0;
    end else begin
      keys_q   <= keys;
      keys_q_d <= keys_q;
    end
  end

  assign rise = keys_q & ~keys_q_d;

  logic signed [VV_W-1:0] voice_val [NUM_KEYS];

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_voice
    localparam logic [HP_W-1:0] HP = HALF_PERIODS[i*HP_W +: HP_W];

    state_t                 st;
    logic [VOL_W-1:0]       vol;
    logic [HP_W-1:0]        hp_cnt;
    logic                   phase;
    logic [TICK_W-1:0]      tick;
    logic                   tick_end;
    logic signed [VV_W-1:0] amp;
    logic signed [VV_W-1:0] v_q;

    assign tick_end = (tick == TICK_LAST);

    always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
        st     <= IDLE;
        vol    <= '0;
        hp_cnt <= '0;
        phase  <= 1'b1;
        tick   <= '0;
      end else begin
        if (st != IDLE) begin
          if (hp_cnt == HP) begin
            hp_cnt <= '0;
            phase  <= ~phase;
          end else begin
            hp_cnt <= hp_cnt + HP_W'(1);
          end
        end
        unique case (st)
          IDLE: begin
            if (rise[i] && HP != '0) begin
              st     <= SUSTAIN;
              vol    <= VOL_LOAD;
              hp_cnt <= '0;
              phase  <= 1'b1;
              tick   <= '0;
            end
          end
          SUSTAIN: begin
            if (!keys_q[i]) st <= RELEASE;
`ifdef VOICE_DECAY_EN
            // decay keeps its tick phase across the move to RELEASE
            if (tick_end) begin
              tick <= '0;
              vol  <= vol - VOL_W'(1);
              if (vol == VOL_W'(1)) st <= IDLE;
            end else begin
              tick <= tick + TICK_W'(1);
            end
`endif
          end
          RELEASE: begin
            if (rise[i]) begin
              st     <= SUSTAIN;
              vol    <= VOL_LOAD;
              hp_cnt <= '0;
              phase  <= 1'b1;
              tick   <= '0;
            end else if (tick_end) begin
              tick <= '0;
              vol  <= vol - VOL_W'(1);
              if (vol == VOL_W'(1)) st <= IDLE;
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign amp = $signed(VV_W'(vol) * VV_W'(AMP_STEP));

    always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
        v_q <= '0;
      end else if (st == IDLE) begin
        v_q <= '0;
      end else begin
        v_q <= phase ? amp : -amp;
      end
    end

    assign voice_val[i]    = v_q;
    assign voice_active[i] = (st != IDLE);
  end

  logic signed [MIX_W-1:0] sum;
  logic signed [31:0]      clip;
  logic signed [31:0]      m_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      sum = sum + MIX_W'(voice_val[i]);
    end
    // symmetric clamp so +full and -full map to equal magnitudes
    if (sum > POS_LIM) begin
      clip = 32'sh7fff_ffff;
    end else if (sum < NEG_LIM) begin
      clip = 32'sh8000_0001;
    end else begin
      clip = sum[31:0];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      m_q <= '0;
    end else begin
      m_q <= clip;
    end
  end

  // write every cycle the FIFO has room, even when silent
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      aud.write_audio_out         <= 1'b0;
      aud.left_channel_audio_out  <= '0;
      aud.right_channel_audio_out <= '0;
    end else begin
      aud.write_audio_out <= aud.audio_out_allowed;
      if (aud.audio_out_allowed) begin
        aud.left_channel_audio_out  <= m_q;
        aud.right_channel_audio_out <= m_q;
      end
    end
  end

endmodule

// File: tb/tb_piano_poly_envelope_synth.sv
// Bench for piano_poly_envelope_synth: event-time reference model,
// two DUTs (normal and saturating amplitude) sharing one stimulus.
module tb_piano_poly_envelope_synth;
  localparam int NK = 2;
  localparam int HPW = 4;
  localparam logic [NK*HPW-1:0] HPS = {4'd4, 4'd2};
  localparam int VI = 4;
  localparam int AS = 10;
  localparam int AS_SAT = 1 << 29;
  localparam int DT = 3;
  localparam int INF = 1 << 30;
  localparam longint LIM = 64'sd2147483647;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NK-1:0] keys = '0;
  logic          allowed = 1'b0;
  logic [NK-1:0] va;
  logic [NK-1:0] va_s;

  piano_poly_envelope_synth_if bus ();
  piano_poly_envelope_synth_if bus_s ();
  assign bus.audio_out_allowed   = allowed;
  assign bus_s.audio_out_allowed = allowed;

  piano_poly_envelope_synth #(
    .NUM_KEYS(NK), .HP_W(HPW), .HALF_PERIODS(HPS), .VOL_W(8),
    .VOL_INIT(VI), .AMP_STEP(AS), .DECAY_TICKS(DT)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .keys(keys),
    .aud(bus), .voice_active(va)
  );

  piano_poly_envelope_synth #(
    .NUM_KEYS(NK), .HP_W(HPW), .HALF_PERIODS(HPS), .VOL_W(8),
    .VOL_INIT(VI), .AMP_STEP(AS_SAT), .DECAY_TICKS(DT)
  ) dut_sat (
    .CLOCK_50(clk), .resetn(resetn), .keys(keys),
    .aud(bus_s), .voice_active(va_s)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // each voice described by the time it entered SUSTAIN and RELEASE
  int     on_t  [NK];
  int     off_t [NK];
  bit     live  [NK];
  logic [NK-1:0] kp1 = '0;
  logic [NK-1:0] kp2 = '0;
  longint mh  [3];
  longint mhs [3];
  longint exp_l = 0;
  longint exp_ls = 0;
  logic   exp_w = 1'b0;
  logic [NK-1:0] exp_va = '0;

  function automatic int hp_of(int i);
    return int'(HPS[i*HPW +: HPW]);
  endfunction

  function automatic int vol_at(int i, int t);
    int v;
`ifdef VOICE_DECAY_EN
    v = VI - (t - on_t[i]) / DT;
`else
    v = (off_t[i] == INF) ? VI : VI - (t - off_t[i]) / DT;
`endif
    return (v < 0) ? 0 : v;
  endfunction

  function automatic longint voice(int i, int t, int amp);
    longint a;
    if (!live[i]) return 0;
    a = longint'(vol_at(i, t)) * amp;
    return (((t - on_t[i]) / (hp_of(i) + 1)) % 2 == 0) ? a : -a;
  endfunction

  function automatic longint clamp(longint s);
    if (s > LIM) return LIM;
    if (s < -LIM) return -LIM;
    return s;
  endfunction

  // advance one clock and update the reference model
  task automatic step();
    longint s;
    longint ss;
    @(posedge clk);
    if (!resetn) begin
      cyc = 0; kp1 = '0; kp2 = '0;
      exp_l = 0; exp_ls = 0; exp_w = 1'b0;
      for (int i = 0; i < NK; i++) live[i] = 0;
      for (int j = 0; j < 3; j++) begin mh[j] = 0; mhs[j] = 0; end
    end else begin
      cyc++;
      for (int i = 0; i < NK; i++) begin
        if (kp1[i] && !kp2[i] && hp_of(i) != 0) begin
          on_t[i] = cyc; off_t[i] = INF; live[i] = 1;
        end else if (live[i]) begin
          if (!kp1[i] && off_t[i] == INF) off_t[i] = cyc;
          if (vol_at(i, cyc) == 0) live[i] = 0;
        end
      end
      s = 0; ss = 0;
      for (int i = 0; i < NK; i++) begin
        s  += voice(i, cyc, AS);
        ss += voice(i, cyc, AS_SAT);
      end
      exp_w = allowed;
      if (allowed) begin
        exp_l  = clamp(mh[2]);
        exp_ls = clamp(mhs[2]);
      end
      mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = s;
      mhs[2] = mhs[1]; mhs[1] = mhs[0]; mhs[0] = ss;
      kp2 = kp1; kp1 = keys;
    end
    for (int i = 0; i < NK; i++) exp_va[i] = live[i];
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; allowed = 1'b1; keys = '0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_chk++;
      if ({bus.write_audio_out, bus.left_channel_audio_out,
           bus.right_channel_audio_out, va} !== '0) begin
        n_fail++;
        $display("FAIL reset k=%0d got w=%b l=%0d r=%0d va=%b want all 0", k,
          bus.write_audio_out, bus.left_channel_audio_out,
          bus.right_channel_audio_out, va);
      end
    end
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_chk++;
      if ({bus.write_audio_out, bus.left_channel_audio_out} !== {1'b1, 32'sd0}) begin
        n_fail++;
        $display("FAIL idle_write k=%0d got w=%b l=%0d want w=1 l=0", k,
          bus.write_audio_out, bus.left_channel_audio_out);
      end
    end
  endtask

  task automatic test_tone();
    keys = 2'b01;
    for (int k = 0; k < 20; k++) begin
      step();
      n_chk++;
      if ({bus.write_audio_out, bus.left_channel_audio_out,
           bus.right_channel_audio_out, va} !==
          {exp_w, exp_l[31:0], exp_l[31:0], exp_va}) begin
        n_fail++;
        $display("FAIL tone cyc=%0d got w=%b l=%0d r=%0d va=%b want w=%b l=%0d va=%b",
          cyc, bus.write_audio_out, bus.left_channel_audio_out,
          bus.right_channel_audio_out, va, exp_w, exp_l, exp_va);
      end
      if (k == 3 || k == 4) begin
        n_chk++;
        if (bus.left_channel_audio_out !== ((k == 4) ? 32'sd40 : 32'sd0)) begin
          n_fail++;
          $display("FAIL tone_latency k=%0d got l=%0d want %0d", k,
            bus.left_channel_audio_out, (k == 4) ? 40 : 0);
        end
      end
    end
  endtask

  task automatic test_release();
    keys = 2'b00;
    for (int k = 0; k < 20; k++) begin
      step();
      n_chk++;
      if ({bus.write_audio_out, bus.left_channel_audio_out,
           bus.right_channel_audio_out, va} !==
          {exp_w, exp_l[31:0], exp_l[31:0], exp_va}) begin
        n_fail++;
        $display("FAIL release cyc=%0d got w=%b l=%0d r=%0d va=%b want w=%b l=%0d va=%b",
          cyc, bus.write_audio_out, bus.left_channel_audio_out,
          bus.right_channel_audio_out, va, exp_w, exp_l, exp_va);
      end
    end
    n_chk++;
    if (va !== 2'b00) begin
      n_fail++;
      $display("FAIL release_idle got va=%b want 00", va);
    end
  endtask

  task automatic test_saturation();
    keys = 2'b11;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) keys = 2'b00;
      step();
      n_chk++;
      if ({bus_s.left_channel_audio_out, bus_s.right_channel_audio_out,
           va_s, bus.left_channel_audio_out} !==
          {exp_ls[31:0], exp_ls[31:0], exp_va, exp_l[31:0]}) begin
        n_fail++;
        $display("FAIL sat cyc=%0d got ls=%0d rs=%0d vas=%b l=%0d want ls=%0d vas=%b l=%0d",
          cyc, bus_s.left_channel_audio_out, bus_s.right_channel_audio_out,
          va_s, bus.left_channel_audio_out, exp_ls, exp_va, exp_l);
      end
      if (k < 20) begin
        n_chk++;
        if (!(bus_s.left_channel_audio_out == 32'sh7fff_ffff ||
              bus_s.left_channel_audio_out == 32'sh8000_0001 ||
              bus_s.left_channel_audio_out == 32'sd0)) begin
          n_fail++;
          $display("FAIL sat_range cyc=%0d got ls=%0d want +-2147483647 or 0",
            cyc, bus_s.left_channel_audio_out);
        end
      end
    end
  endtask

  task automatic test_handshake();
    logic [15:0] pat;
    pat = 16'b1101_0011_1011_0101;
    keys = 2'b01;
    for (int k = 0; k < 36; k++) begin
      allowed = (k < 16) ? pat[k] : 1'b1;
      if (k == 16) keys = 2'b00;
      step();
      n_chk++;
      if ({bus.write_audio_out, bus.left_channel_audio_out,
           bus.right_channel_audio_out, va} !==
          {exp_w, exp_l[31:0], exp_l[31:0], exp_va}) begin
        n_fail++;
        $display("FAIL handshake cyc=%0d got w=%b l=%0d r=%0d va=%b want w=%b l=%0d va=%b",
          cyc, bus.write_audio_out, bus.left_channel_audio_out,
          bus.right_channel_audio_out, va, exp_w, exp_l, exp_va);
      end
    end
    allowed = 1'b1;
  endtask

  task automatic test_retrigger();
    bit hit;
    keys = 2'b01;
    step();
    step();
    keys = 2'b00;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      step();
      n_chk++;
      if ({bus.left_channel_audio_out, va} !== {exp_l[31:0], exp_va}) begin
        n_fail++;
        $display("FAIL retrig_fall cyc=%0d got l=%0d va=%b want l=%0d va=%b",
          cyc, bus.left_channel_audio_out, va, exp_l, exp_va);
      end
      if (live[0] && vol_at(0, cyc) == 2) hit = 1;
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL retrig_wait got no vol 2 within 40 cycles want vol 2");
    end
    keys = 2'b01;
    for (int k = 0; k < 24; k++) begin
      step();
      n_chk++;
      if ({bus.write_audio_out, bus.left_channel_audio_out,
           bus.right_channel_audio_out, va} !==
          {exp_w, exp_l[31:0], exp_l[31:0], exp_va}) begin
        n_fail++;
        $display("FAIL retrig cyc=%0d got w=%b l=%0d r=%0d va=%b want w=%b l=%0d va=%b",
          cyc, bus.write_audio_out, bus.left_channel_audio_out,
          bus.right_channel_audio_out, va, exp_w, exp_l, exp_va);
      end
    end
    n_chk++;
`ifdef VOICE_DECAY_EN
    if (va[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL retrig_hold got va0=%b want 0", va[0]);
    end
`else
    if (va[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL retrig_hold got va0=%b want 1", va[0]);
    end
`endif
    keys = 2'b00;
    for (int k = 0; k < 20; k++) step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 5) == 0) keys = 2'($urandom_range(0, 3));
      allowed = ($urandom_range(0, 3) != 0);
      step();
      n_chk++;
      if ({bus.write_audio_out, bus.left_channel_audio_out,
           bus.right_channel_audio_out, va, bus_s.left_channel_audio_out} !==
          {exp_w, exp_l[31:0], exp_l[31:0], exp_va, exp_ls[31:0]}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got w=%b l=%0d r=%0d va=%b ls=%0d want w=%b l=%0d va=%b ls=%0d",
          cyc, bus.write_audio_out, bus.left_channel_audio_out,
          bus.right_channel_audio_out, va, bus_s.left_channel_audio_out,
          exp_w, exp_l, exp_va, exp_ls);
      end
    end
    allowed = 1'b1;
    keys = 2'b11;
    for (int k = 0; k < 6; k++) step();
    resetn = 1'b0;
    step();
    n_chk++;
    if ({bus.write_audio_out, bus.left_channel_audio_out, va,
         bus_s.left_channel_audio_out, va_s} !== '0) begin
      n_fail++;
      $display("FAIL midnote_reset got w=%b l=%0d va=%b ls=%0d vas=%b want all 0",
        bus.write_audio_out, bus.left_channel_audio_out, va,
        bus_s.left_channel_audio_out, va_s);
    end
    resetn = 1'b1;
    keys = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_tone();
    test_release();
    test_saturation();
    test_handshake();
    test_retrigger();
    test_random();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
